gen3_scrambler_nb: RTL and testbench

- Registered, multi-byte-per-cycle PCIe Gen3 (128b/130b) scrambler for one lane.
- Sits between the block framer and the gearbox. Scrambles NBYTES symbols per beat.
- Tracks position within each 16-symbol block and applies the Gen3 ordered-set exceptions: EIEOS reseed, SKP hold, and symbol-0 bypass.
- Lane seed is selected by parameter.

---
 rtl/gen3_scrambler_nb.sv | 138 +++++++++++++
 tb/tb_gen3_scrambler_nb.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gen3_scrambler_nb.sv
// PCIe Gen3 128b/130b lane scrambler, NBYTES symbols per beat.
// Tracks block position and applies the SKP/EIEOS/symbol-0 exceptions.
module gen3_scrambler_nb #(
    parameter int NBYTES  = 4,
    parameter int LANE_ID = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  scramble_enable_i,
    input  logic                  seed_load_i,
    input  logic                  valid_i,
    input  logic                  block_start_i,
    input  logic [1:0]            sync_hdr_i,
    input  logic [8*NBYTES-1:0]   data_i,
    output logic                  valid_o,
    output logic                  block_start_o,
    output logic [1:0]            sync_hdr_o,
    output logic [8*NBYTES-1:0]   data_o,
    output logic                  proto_err_o
);

    localparam logic [183:0] SEED_TAB = {
        23'h1BB807, 23'h0277CE, 23'h19CFC9, 23'h010F12,
        23'h18C0DB, 23'h1EC760, 23'h0607BB, 23'h1DBFBC
    };
    localparam logic [22:0] SEED = SEED_TAB[23*(LANE_ID%8) +: 23];
    localparam logic [22:0] TAPS = 23'h210125;
    localparam logic [3:0]  NB4  = 4'(NBYTES);

    typedef enum logic [2:0] {
        IDLE, DATA, OS_SKP, OS_EIEOS, OS_OTHER
    } state_t;

    state_t              state;
    state_t              st_cur;
    logic [22:0]         lfsr;
    logic [22:0]         lfsr_run;
    logic [22:0]         lfsr_nxt;
    logic [3:0]          cnt;
    logic [3:0]          cnt_cur;
    logic [3:0]          pos;
    logic [1:0]          hdr;
    logic [1:0]          hdr_cur;
    logic [8*NBYTES-1:0] scr_data;
    logic                bad_hdr;
    logic                err;
    logic                adv;
    logic                scr;
    logic                fb;
    logic                blk_end;

    // A block_start beat decodes its own header and restarts at symbol 0
    always_comb begin
        hdr_cur = hdr;
        st_cur  = state;
        cnt_cur = cnt;
        bad_hdr = 1'b0;
        if (block_start_i) begin
            hdr_cur = sync_hdr_i;
            cnt_cur = 4'd0;
            unique case (sync_hdr_i)
                2'b10: st_cur = DATA;
                2'b01: begin
                    if (data_i[7:0] == 8'hAA)
                        st_cur = OS_SKP;
                    else if (data_i[7:0] == 8'h00)
                        st_cur = OS_EIEOS;
                    else
                        st_cur = OS_OTHER;
                end
                default: begin
                    st_cur  = DATA;
                    bad_hdr = 1'b1;
                end
            endcase
        end
        err = valid_i &
              ((block_start_i & (bad_hdr | (cnt != 4'd0))) |
               (~block_start_i & (state == IDLE)));
    end

    always_comb begin
        lfsr_run = seed_load_i ? SEED : lfsr;
        scr_data = data_i;
        blk_end  = 1'b0;
        pos      = cnt_cur;
        adv      = 1'b0;
        scr      = 1'b0;
        fb       = 1'b0;
        for (int k = 0; k < NBYTES; k++) begin
            pos = cnt_cur + 4'(k);
            adv = scramble_enable_i &&
                  (st_cur == DATA || st_cur == OS_OTHER);
            scr = adv && !(st_cur == OS_OTHER && pos == 4'd0);
            if (scramble_enable_i && st_cur == OS_EIEOS &&
                pos == 4'd15)
                blk_end = 1'b1;
            for (int j = 0; j < 8; j++) begin
                fb = lfsr_run[22];
                scr_data[8*k+j] = scr_data[8*k+j] ^ (scr & fb);
                if (adv)
                    lfsr_run = {lfsr_run[21:0], 1'b0} ^
                               (TAPS & {23{fb}});
            end
        end
        if (!valid_i)
            lfsr_nxt = seed_load_i ? SEED : lfsr;
        else
            lfsr_nxt = blk_end ? SEED : lfsr_run;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr          <= SEED;
            cnt           <= 4'd0;
            state         <= IDLE;
            hdr           <= 2'b00;
            valid_o       <= 1'b0;
            block_start_o <= 1'b0;
            proto_err_o   <= 1'b0;
            data_o        <= '0;
            sync_hdr_o    <= 2'b00;
        end else begin
            valid_o       <= valid_i;
            block_start_o <= valid_i & block_start_i;
            proto_err_o   <= err;
            lfsr          <= lfsr_nxt;
            if (valid_i) begin
                cnt        <= cnt_cur + NB4;
                state      <= st_cur;
                hdr        <= hdr_cur;
                data_o     <= scr_data;
                sync_hdr_o <= hdr_cur;
            end
        end
    end

endmodule

// File: tb/tb_gen3_scrambler_nb.sv
// Bench for gen3_scrambler_nb: three lane/width variants checked
// against a symbol-serial keystream model plus a directed vector table.
module tb_gen3_scrambler_nb;

    localparam int T_IDLE = 0;
    localparam int T_DATA = 1;
    localparam int T_SKP  = 2;
    localparam int T_EIE  = 3;
    localparam int T_OTH  = 4;

    logic clk;
    logic rst;
    logic eni [3];
    logic sli [3];
    logic vi  [3];
    logic bsi [3];
    logic [1:0]   hi [3];
    logic [127:0] di [3];
    logic vo  [3];
    logic bso [3];
    logic errw[3];
    logic [1:0]   ho [3];
    logic [31:0]  q0;
    logic [7:0]   q1;
    logic [127:0] q2;

    int nchk = 0;
    int nfail = 0;

    int          nbv [3] = '{4, 1, 16};
    logic [22:0] seedv [3] = '{23'h1DBFBC, 23'h19CFC9, 23'h19CFC9};
    logic [22:0]  ml [3];
    int           mc [3];
    int           mt [3];
    logic [1:0]   mh [3];
    logic [127:0] md [3];

    gen3_scrambler_nb #(.NBYTES(4), .LANE_ID(0)) u0 (
        .clk_i(clk), .rst_i(rst),
        .scramble_enable_i(eni[0]), .seed_load_i(sli[0]),
        .valid_i(vi[0]), .block_start_i(bsi[0]),
        .sync_hdr_i(hi[0]), .data_i(di[0][31:0]),
        .valid_o(vo[0]), .block_start_o(bso[0]),
        .sync_hdr_o(ho[0]), .data_o(q0), .proto_err_o(errw[0])
    );

    gen3_scrambler_nb #(.NBYTES(1), .LANE_ID(5)) u1 (
        .clk_i(clk), .rst_i(rst),
        .scramble_enable_i(eni[1]), .seed_load_i(sli[1]),
        .valid_i(vi[1]), .block_start_i(bsi[1]),
        .sync_hdr_i(hi[1]), .data_i(di[1][7:0]),
        .valid_o(vo[1]), .block_start_o(bso[1]),
        .sync_hdr_o(ho[1]), .data_o(q1), .proto_err_o(errw[1])
    );

    gen3_scrambler_nb #(.NBYTES(16), .LANE_ID(13)) u2 (
        .clk_i(clk), .rst_i(rst),
        .scramble_enable_i(eni[2]), .seed_load_i(sli[2]),
        .valid_i(vi[2]), .block_start_i(bsi[2]),
        .sync_hdr_i(hi[2]), .data_i(di[2]),
        .valid_o(vo[2]), .block_start_o(bso[2]),
        .sync_hdr_o(ho[2]), .data_o(q2), .proto_err_o(errw[2])
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] outp(input int i);
        case (i)
            0: return {96'd0, q0};
            1: return {120'd0, q1};
            default: return q2;
        endcase
    endfunction

    function automatic logic [127:0] mask(input int i);
        if (nbv[i] == 16) return '1;
        return (128'd1 << (8*nbv[i])) - 128'd1;
    endfunction

    task automatic chk(input string n, input int i,
                       input logic [127:0] a, input logic [127:0] x);
        nchk++;
        if (a !== x) begin
            nfail++;
            $display("FAIL %s inst=%0d got=%h want=%h", n, i, a, x);
        end
    endtask

    // Serial keystream: one symbol, bit by bit, LSB first
    function automatic logic [7:0] ks_sym(input int i, input logic [7:0] d,
                                         input bit s, input bit a);
        logic [7:0] r;
        logic b;
        r = d;
        for (int j = 0; j < 8; j++) begin
            b = ml[i][22];
            if (s) r[j] = r[j] ^ b;
            if (a) ml[i] = (ml[i] << 1) ^ (b ? 23'h210125 : 23'h0);
        end
        return r;
    endfunction

    function automatic void model(input int i, input bit bs,
                                  input logic [1:0] h,
                                  input logic [127:0] d,
                                  input bit en, input bit sl,
                                  output logic [127:0] q,
                                  output bit e);
        logic [7:0] sym;
        bit s, a;
        e = 0;
        if (sl) ml[i] = seedv[i];
        if (bs) begin
            if (mc[i] != 0) e = 1;
            mc[i] = 0;
            mh[i] = h;
            if (h == 2'b01) begin
                if (d[7:0] == 8'hAA) mt[i] = T_SKP;
                else if (d[7:0] == 8'h00) mt[i] = T_EIE;
                else mt[i] = T_OTH;
            end else begin
                mt[i] = T_DATA;
                if (h != 2'b10) e = 1;
            end
        end else if (mt[i] == T_IDLE) begin
            e = 1;
        end
        q = d;
        for (int k = 0; k < nbv[i]; k++) begin
            sym = d[8*k +: 8];
            a = en && (mt[i] == T_DATA || mt[i] == T_OTH);
            s = a && !(mt[i] == T_OTH && mc[i] == 0);
            q[8*k +: 8] = ks_sym(i, sym, s, a);
            if (en && mt[i] == T_EIE && mc[i] == 15)
                ml[i] = seedv[i];
            mc[i] = (mc[i] + 1) % 16;
        end
        md[i] = q;
    endfunction

    task automatic step(input int i, input bit v, input bit b,
                        input logic [1:0] h, input logic [127:0] d,
                        input bit e, input bit s,
                        output logic [127:0] q);
        bit xe;
        vi[i] = v; bsi[i] = b; hi[i] = h;
        di[i] = d; eni[i] = e; sli[i] = s;
        @(posedge clk);
        #1;
        if (v) begin
            model(i, b, h, d, e, s, q, xe);
        end else begin
            if (s) ml[i] = seedv[i];
            q = md[i];
            xe = 0;
        end
        chk("valid_o", i, {127'd0, vo[i]}, {127'd0, v});
        chk("proto_err", i, {127'd0, errw[i]}, {127'd0, xe});
        chk("data_o", i, outp(i), q & mask(i));
        if (v) begin
            chk("block_start_o", i, {127'd0, bso[i]}, {127'd0, b});
            chk("sync_hdr_o", i, {126'd0, ho[i]}, {126'd0, mh[i]});
        end
        vi[i] = 0; bsi[i] = 0; sli[i] = 0;
    endtask

    task automatic do_reset(input bit inflight);
        rst = 1;
        vi[0] = inflight; bsi[0] = inflight;
        hi[0] = 2'b10; eni[0] = 1;
        @(posedge clk);
        #1;
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            vi[i] = 0; bsi[i] = 0; sli[i] = 0;
            ml[i] = seedv[i]; mc[i] = 0; mt[i] = T_IDLE;
            mh[i] = 2'b00; md[i] = '0;
            chk("rst_valid", i, {127'd0, vo[i]}, 128'd0);
            chk("rst_err", i, {127'd0, errw[i]}, 128'd0);
            chk("rst_bs", i, {127'd0, bso[i]}, 128'd0);
            chk("rst_data", i, outp(i), 128'd0);
            chk("rst_hdr", i, {126'd0, ho[i]}, 128'd0);
        end
    endtask

    typedef struct {
        bit          bs;
        logic [1:0]  h;
        logic [31:0] d;
        logic [31:0] xd;
        logic [31:0] xm;
        bit          xe;
    } vec_t;

    vec_t tbl [22];

    initial begin
        logic [127:0] q;
        logic [127:0] d;
        logic [7:0]   s0;
        int           typ;
        bit           en;

        tbl = '{
            '{1, 2'b01, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'hFFFFFFFF, 0},
            '{0, 2'b01, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'hFFFFFFFF, 0},
            '{0, 2'b01, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'hFFFFFFFF, 0},
            '{0, 2'b01, 32'h5A3CE1AA, 32'h5A3CE1AA, 32'hFFFFFFFF, 0},
            '{1, 2'b10, 32'h00000000, 32'h0000006C, 32'h000000FF, 0},
            '{0, 2'b10, 32'h00000000, 32'h00000000, 32'h00000000, 0},
            '{0, 2'b10, 32'h00000000, 32'h00000000, 32'h00000000, 0},
            '{0, 2'b10, 32'h00000000, 32'h00000000, 32'h00000000, 0},
            '{1, 2'b01, 32'hFF00FF00, 32'hFF00FF00, 32'hFFFFFFFF, 0},
            '{0, 2'b01, 32'hFF00FF00, 32'hFF00FF00, 32'hFFFFFFFF, 0},
            '{0, 2'b01, 32'hFF00FF00, 32'hFF00FF00, 32'hFFFFFFFF, 0},
            '{0, 2'b01, 32'hFF00FF00, 32'hFF00FF00, 32'hFFFFFFFF, 0},
            '{1, 2'b10, 32'h00000000, 32'h0000006C, 32'h000000FF, 0},
            '{0, 2'b10, 32'h00000000, 32'h00000000, 32'h00000000, 0},
            '{0, 2'b10, 32'h00000000, 32'h00000000, 32'h00000000, 0},
            '{0, 2'b10, 32'h00000000, 32'h00000000, 32'h00000000, 0},
            '{1, 2'b01, 32'h00F7F71E, 32'h0000001E, 32'h000000FF, 0},
            '{0, 2'b01, 32'h00000000, 32'h00000000, 32'h00000000, 0},
            '{1, 2'b10, 32'h00000000, 32'h00000000, 32'h00000000, 1},
            '{0, 2'b10, 32'h00000000, 32'h00000000, 32'h00000000, 0},
            '{0, 2'b10, 32'h00000000, 32'h00000000, 32'h00000000, 0},
            '{0, 2'b10, 32'h00000000, 32'h00000000, 32'h00000000, 0}
        };

        clk = 0;
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            eni[i] = 1; sli[i] = 0; vi[i] = 0; bsi[i] = 0;
            hi[i] = 2'b00; di[i] = '0;
        end
        do_reset(0);

        for (int r = 0; r < 22; r++) begin
            step(0, 1, tbl[r].bs, tbl[r].h, {96'd0, tbl[r].d}, 1, 0, q);
            chk("tbl_data", 0, {96'd0, q0 & tbl[r].xm},
                {96'd0, tbl[r].xd & tbl[r].xm});
            chk("tbl_err", 0, {127'd0, errw[0]}, {127'd0, tbl[r].xe});
        end

        // Bad sync header is an error, block treated as data
        step(0, 1, 1, 2'b00, 128'd0, 1, 0, q);
        chk("bad_hdr_err", 0, {127'd0, errw[0]}, 128'd1);

        // Valid beat in IDLE passes through with an error
        do_reset(0);
        d = {96'd0, 32'hC0FFEE11};
        step(0, 1, 0, 2'b10, d, 1, 0, q);
        chk("idle_pass", 0, {96'd0, q0}, d);
        chk("idle_err", 0, {127'd0, errw[0]}, 128'd1);

        // Bypass block, then scrambling resumes from held LFSR
        do_reset(0);
        for (int b = 0; b < 4; b++) begin
            d = {96'd0, $urandom};
            step(0, 1, b == 0, 2'b10, d, 0, 0, q);
            chk("bypass", 0, {96'd0, q0}, d);
        end
        step(0, 1, 1, 2'b10, 128'd0, 1, 0, q);
        chk("after_bypass", 0, {120'd0, q0[7:0]}, 128'h6C);
        step(0, 1, 0, 2'b10, 128'd0, 1, 0, q);
        step(0, 1, 0, 2'b10, 128'd0, 1, 1, q);
        chk("seed_load", 0, {120'd0, q0[7:0]}, 128'h6C);
        step(0, 0, 0, 2'b10, 128'd0, 1, 0, q);
        step(0, 1, 0, 2'b10, 128'd0, 1, 0, q);

        // Reset mid-block drops the beat in flight
        step(0, 1, 1, 2'b10, {96'd0, $urandom}, 1, 0, q);
        do_reset(1);

        for (int i = 0; i < 3; i++) begin
            for (int blk = 0; blk < 30; blk++) begin
                typ = $urandom_range(0, 9);
                en = ($urandom_range(0, 7) != 0);
                case (typ)
                    6: s0 = 8'hAA;
                    7: s0 = 8'h00;
                    8: s0 = 8'h1E;
                    9: s0 = 8'h2D;
                    default: s0 = 8'($urandom);
                endcase
                for (int b = 0; b < 16 / nbv[i]; b++) begin
                    if ($urandom_range(0, 5) == 0)
                        step(i, 0, 0, 2'b10, 128'd0, en, 0, q);
                    d = {$urandom, $urandom, $urandom, $urandom};
                    d = d & mask(i);
                    if (b == 0) d[7:0] = s0;
                    step(i, 1, b == 0, (typ < 6) ? 2'b10 : 2'b01, d,
                         en, $urandom_range(0, 40) == 0, q);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
